// File: rtl/at_pkg.sv
// Shared types for the attribute staging path: word width, stored word
// layout (data plus primitive-boundary flag) and FIFO state encoding.
package at_pkg;

    localparam int AT_WORD_W = 64;

    typedef struct packed {
        logic                 last;
        logic [AT_WORD_W-1:0] data;
    } at_word_t;

    typedef enum logic {
        AT_FIFO_RUN   = 1'b0,
        AT_FIFO_FLUSH = 1'b1
    } at_fifo_state_e;

endpackage

// File: rtl/at_attr_ram.sv
// DEPTH x 65 register-file storage for the attribute FIFO: one synchronous
// write port, one asynchronous read port. Kept separate so a library RAM can replace it.
module at_attr_ram
    import at_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          gclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  at_word_t      wdata,
    input  logic [AW-1:0] raddr,
    output at_word_t      rdata
);

    at_word_t mem [DEPTH];

    always_ff @(posedge gclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/at_attr_fifo.sv
// Attribute staging FIFO: valid/ready write side, registered read word per
// granted request, occupancy and stored-primitive counters, flush control.
//
//   state         | meaning
//   --------------+---------------------------------------------------------
//   AT_FIFO_RUN   | normal operation; writes accepted and reads granted
//   AT_FIFO_FLUSH | pointers and counters held clear; no writes, no grants
module at_attr_fifo
    import at_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                 gclk,
    input  logic                 reset,
    input  logic                 wr_valid,
    input  logic [AT_WORD_W-1:0] wr_data,
    input  logic                 wr_last,
    output logic                 wr_ready,
    input  logic                 rd_req,
    output logic [AT_WORD_W-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_last,
    input  logic                 flush,
    output logic [AW:0]          count,
    output logic [AW:0]          prim_cnt
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    at_fifo_state_e state;
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    at_word_t       wr_word;
    at_word_t       rd_word;
    logic           accept;
    logic           grant;
    logic           prim_inc;
    logic           prim_dec;
    logic [AW:0]    count_next;
    logic [AW:0]    prim_next;

    // Ready depends only on registered state so the producer never sees rd_req ripple through.
    assign wr_ready = (count != FULL) && (state == AT_FIFO_RUN);
    assign accept   = wr_valid && wr_ready && !flush;
    assign grant    = rd_req && (count != '0) && (state == AT_FIFO_RUN) && !flush;
    assign wr_word  = '{last: wr_last, data: wr_data};
    assign prim_inc = accept && wr_last;
    assign prim_dec = grant && rd_word.last;

    at_attr_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .gclk  (gclk),
        .we    (accept),
        .waddr (wp),
        .wdata (wr_word),
        .raddr (rp),
        .rdata (rd_word)
    );

    always_comb begin
        count_next = count;
        prim_next  = prim_cnt;
        case ({accept, grant})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
        case ({prim_inc, prim_dec})
            2'b10:   prim_next = prim_cnt + (AW+1)'(1);
            2'b01:   prim_next = prim_cnt - (AW+1)'(1);
            default: prim_next = prim_cnt;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (reset) begin
            state    <= AT_FIFO_RUN;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            prim_cnt <= '0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= grant;
            if (grant) begin
                rd_data <= rd_word.data;
                rd_last <= rd_word.last;
                rp      <= rp + AW'(1);
            end
            if (accept) begin
                wp <= wp + AW'(1);
            end
            count    <= count_next;
            prim_cnt <= prim_next;

            // Flush discards on the very edge it is seen; rd_data/rd_last keep their value.
            case (state)
                AT_FIFO_RUN: begin
                    if (flush) begin
                        state    <= AT_FIFO_FLUSH;
                        wp       <= '0;
                        rp       <= '0;
                        count    <= '0;
                        prim_cnt <= '0;
                    end
                end
                AT_FIFO_FLUSH: begin
                    wp       <= '0;
                    rp       <= '0;
                    count    <= '0;
                    prim_cnt <= '0;
                    if (!flush) begin
                        state <= AT_FIFO_RUN;
                    end
                end
                default: state <= AT_FIFO_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_at_attr_fifo.sv
// Self-checking bench for at_attr_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_at_attr_fifo;
    import at_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic                 gclk = 1'b0;
    logic                 reset;
    logic                 wr_valid;
    logic [AT_WORD_W-1:0] wr_data;
    logic                 wr_last;
    logic                 wr_ready;
    logic                 rd_req;
    logic [AT_WORD_W-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_last;
    logic                 flush;
    logic [AW:0]          count;
    logic [AW:0]          prim_cnt;

    int n_checks = 0;
    int n_errors = 0;

    at_attr_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .gclk     (gclk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .flush    (flush),
        .count    (count),
        .prim_cnt (prim_cnt)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the visible read register.
    at_word_t       q[$];
    logic [63:0]    m_data    = '0;
    logic           m_last    = 1'b0;
    logic           m_valid   = 1'b0;
    logic           m_flushed = 1'b0;
    logic           m_started = 1'b0;

    function automatic int m_prims();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    function automatic logic m_ready();
        return (q.size() != DEPTH) && !m_flushed;
    endfunction

    always @(posedge gclk) begin
        at_word_t w;
        logic     acc;
        logic     grt;
        if (reset) begin
            q.delete();
            m_data    = '0;
            m_last    = 1'b0;
            m_valid   = 1'b0;
            m_flushed = 1'b0;
            m_started = 1'b1;
        end else if (m_started) begin
            acc = wr_valid && m_ready() && !flush;
            grt = rd_req && (q.size() > 0) && !m_flushed && !flush;
            m_valid = grt;
            if (grt) begin
                w      = q.pop_front();
                m_data = w.data;
                m_last = w.last;
            end
            if (acc) q.push_back('{last: wr_last, data: wr_data});
            if (flush || m_flushed) q.delete();
            m_flushed = flush;
        end
    end

    always @(negedge gclk) begin
        if (m_started) begin
            chk("rd_valid", 64'(rd_valid), 64'(m_valid));
            chk("rd_data",  rd_data, m_data);
            chk("rd_last",  64'(rd_last), 64'(m_last));
            chk("count",    64'(count), 64'(q.size()));
            chk("prim_cnt", 64'(prim_cnt), 64'(m_prims()));
            chk("wr_ready", 64'(wr_ready), 64'(m_ready()));
        end
    end

    task automatic step(input logic rst, input logic wv, input logic [63:0] wd,
                        input logic wl, input logic rq, input logic fl);
        reset    = rst;
        wr_valid = wv;
        wr_data  = wd;
        wr_last  = wl;
        rd_req   = rq;
        flush    = fl;
        @(posedge gclk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        rd_req = 1'b0; flush = 1'b0;
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_wr_ready", 64'(wr_ready), 64'd1);
        idle();

        // Three words, last on the third
        step(1'b0, 1'b1, 64'hA0A0_0000_0000_00A0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 64'hA1A1_0000_0000_00A1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 64'hA2A2_0000_0000_00A2, 1'b1, 1'b0, 1'b0);
        chk("t1_count3", 64'(count), 64'd3);
        chk("t1_prim1", 64'(prim_cnt), 64'd1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_rd0", rd_data, 64'hA0A0_0000_0000_00A0);
        chk("t1_last0", 64'(rd_last), 64'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_rd1", rd_data, 64'hA1A1_0000_0000_00A1);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_rd2", rd_data, 64'hA2A2_0000_0000_00A2);
        chk("t1_last2", 64'(rd_last), 64'd1);
        chk("t1_prim0", 64'(prim_cnt), 64'd0);
        chk("t1_count0", 64'(count), 64'd0);
        idle();

        // Fill to full, then read while attempting a write
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 64'hB000 + 64'(i), 1'(i == 3), 1'b0, 1'b0);
        chk("t2_full_ready", 64'(wr_ready), 64'd0);
        chk("t2_full_count", 64'(count), 64'd8);
        step(1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("t2_after_count", 64'(count), 64'd7);
        chk("t2_after_ready", 64'(wr_ready), 64'd1);
        chk("t2_rd_b0", rd_data, 64'hB000);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
            chk("t2_drain", rd_data, 64'hB000 + 64'(i));
        end
        chk("t2_empty", 64'(count), 64'd0);
        idle();

        // Streaming write+read with two words in flight; pointers wrap
        step(1'b0, 1'b1, 64'hC000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 64'hC001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 64'hC002 + 64'(i), 1'((i % 3) == 0), 1'b1, 1'b0);
            chk("t3_count", 64'(count), 64'd2);
            chk("t3_order", rd_data, 64'hC000 + 64'(i));
            chk("t3_valid", 64'(rd_valid), 64'd1);
        end
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t3_tail", rd_data, 64'hC015);
        idle();

        // Read on empty, then write with rd_req held
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t4_empty_valid", 64'(rd_valid), 64'd0);
        step(1'b0, 1'b1, 64'hD0D0, 1'b1, 1'b1, 1'b0);
        chk("t4_no_bypass", 64'(rd_valid), 64'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t4_valid", 64'(rd_valid), 64'd1);
        chk("t4_data", rd_data, 64'hD0D0);
        idle();

        // Flush with a simultaneous write and read
        step(1'b0, 1'b1, 64'hE000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++)
            step(1'b0, 1'b1, 64'hE000 + 64'(i), 1'(i == 2), 1'b0, 1'b0);
        chk("t5_count5", 64'(count), 64'd5);
        step(1'b0, 1'b1, 64'hBAD0, 1'b1, 1'b1, 1'b1);
        chk("t5_count0", 64'(count), 64'd0);
        chk("t5_prim0", 64'(prim_cnt), 64'd0);
        chk("t5_hold", rd_data, 64'hE000);
        chk("t5_ready0", 64'(wr_ready), 64'd0);
        idle();
        chk("t5_ready1", 64'(wr_ready), 64'd1);
        step(1'b0, 1'b1, 64'hF000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t5_new", rd_data, 64'hF000);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t5_no_dropped", 64'(rd_valid), 64'd0);

        // Reset mid-stream with four words stored
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 64'h6000 + 64'(i), 1'b1, 1'b0, 1'b0);
        chk("t6_count4", 64'(count), 64'd4);
        step(1'b1, 1'b1, 64'h6666, 1'b0, 1'b1, 1'b0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_prim", 64'(prim_cnt), 64'd0);
        chk("t6_data", rd_data, 64'h0);
        chk("t6_valid", 64'(rd_valid), 64'd0);
        step(1'b0, 1'b1, 64'h7007, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t6_new", rd_data, 64'h7007);
        step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("t6_only_new", 64'(rd_valid), 64'd0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
